// File: rtl/instr_fetch_stage_if.sv
// Bundle of control inputs, the instruction-memory path and the IF/ID register outputs of the fetch stage.
// master = surrounding pipeline/memory, slave = the fetch stage itself.
interface instr_fetch_stage_if;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [25:0] JumpIndex;
   logic [31:0] ImemInstruction;
   logic [31:0] ImemAddress;
   logic [31:0] IfId_Instruction;
   logic [31:0] IfId_PCPlus4;
   logic        IfId_Valid;
   logic [31:0] FetchCount;

   modport master (
      output Stall, BranchTaken, BranchTarget, Jump, JumpIndex, ImemInstruction,
      input  ImemAddress, IfId_Instruction, IfId_PCPlus4, IfId_Valid, FetchCount
   );

   modport slave (
      input  Stall, BranchTaken, BranchTarget, Jump, JumpIndex, ImemInstruction,
      output ImemAddress, IfId_Instruction, IfId_PCPlus4, IfId_Valid, FetchCount
   );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, addresses an async-read instruction memory and fills the IF/ID register.
// Priority per edge: branch, then jump, then stall, else sequential fetch.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic                 Clk,
   input logic                 Reset,
   instr_fetch_stage_if.slave  fetch
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_plus4;

   // Branch targets are word-aligned by discarding the byte-offset bits.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^fetch.BranchTarget[1:0];

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned (no latch).
      pc_d            = pc_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_valid_d    = ifid_valid_q;
      fetch_count_d   = fetch_count_q;

      if (fetch.BranchTaken) begin
         pc_d            = {fetch.BranchTarget[31:2], 2'b00};
         ifid_instr_d    = NOP_INSTR;
         ifid_pc_plus4_d = 32'd0;
         ifid_valid_d    = 1'b0;
      end else if (fetch.Jump) begin
         // The jump sits in IF/ID, so its region bits come from the registered PC+4.
         pc_d            = {ifid_pc_plus4_q[31:28], fetch.JumpIndex, 2'b00};
         ifid_instr_d    = NOP_INSTR;
         ifid_pc_plus4_d = 32'd0;
         ifid_valid_d    = 1'b0;
      end else if (!fetch.Stall) begin
         pc_d            = pc_plus4;
         ifid_instr_d    = fetch.ImemInstruction;
         ifid_pc_plus4_d = pc_plus4;
         ifid_valid_d    = 1'b1;
         if (fetch_count_q != '1) begin
            fetch_count_d = fetch_count_q + 32'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q            <= {RESET_PC[31:2], 2'b00};
         ifid_instr_q    <= NOP_INSTR;
         ifid_pc_plus4_q <= 32'd0;
         ifid_valid_q    <= 1'b0;
         fetch_count_q   <= 32'd0;
      end else begin
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_valid_q    <= ifid_valid_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign fetch.ImemAddress      = pc_q;
   assign fetch.IfId_Instruction = ifid_instr_q;
   assign fetch.IfId_PCPlus4     = ifid_pc_plus4_q;
   assign fetch.IfId_Valid       = ifid_valid_q;
   assign fetch.FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a small async-read memory model and hand-computed expectations.
module tb_instr_fetch_stage;

   logic Clk;
   logic Reset;
   int   checks;
   int   errors;

   instr_fetch_stage_if bus ();

   instr_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .fetch (bus)
   );

   logic [31:0] mem [0:127];
   assign bus.ImemInstruction = mem[bus.ImemAddress[8:2]];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                             input logic valid, input logic [31:0] cnt, input logic [31:0] addr);
      check({tag, ".instr"}, bus.IfId_Instruction, instr);
      check({tag, ".pc4"},   bus.IfId_PCPlus4, pc4);
      check({tag, ".valid"}, {31'd0, bus.IfId_Valid}, {31'd0, valid});
      check({tag, ".count"}, bus.FetchCount, cnt);
      check({tag, ".addr"},  bus.ImemAddress, addr);
   endtask

   task automatic idle_inputs();
      bus.Stall        = 1'b0;
      bus.BranchTaken  = 1'b0;
      bus.BranchTarget = 32'd0;
      bus.Jump         = 1'b0;
      bus.JumpIndex    = 26'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h2010_000e;
      mem[1] = 32'h2011_000f;
      mem[2] = 32'h2012_001d;
      idle_inputs();
      Reset = 1'b0;

      // T1: reset values, held across an edge while reset is low
      #2;
      check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
      step();
      check_ifid("rst_hold", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
      Reset = 1'b1;
      step();
      check_ifid("f0", 32'h2010_000e, 32'd4, 1'b1, 32'd1, 32'd4);
      step();
      check_ifid("f1", 32'h2011_000f, 32'd8, 1'b1, 32'd2, 32'd8);
      step();
      check_ifid("f2", 32'h2012_001d, 32'd12, 1'b1, 32'd3, 32'd12);

      // T2: stall two cycles holds PC, IF/ID and count
      bus.Stall = 1'b1;
      step();
      check_ifid("stall1", 32'h2012_001d, 32'd12, 1'b1, 32'd3, 32'd12);
      step();
      check_ifid("stall2", 32'h2012_001d, 32'd12, 1'b1, 32'd3, 32'd12);
      bus.Stall = 1'b0;
      step();
      check_ifid("resume", 32'h1000_0003, 32'd16, 1'b1, 32'd4, 32'd16);

      // T3: branch during stall wins, target low bits dropped
      bus.Stall        = 1'b1;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h43;
      step();
      check_ifid("br_stall", 32'h0, 32'h0, 1'b0, 32'd4, 32'h40);
      idle_inputs();
      step();
      check_ifid("br_tgt", 32'h1000_0010, 32'h44, 1'b1, 32'd5, 32'h44);

      // T4: jump, then jump squashed by simultaneous branch
      bus.Jump      = 1'b1;
      bus.JumpIndex = 26'h5;
      step();
      check_ifid("jmp", 32'h0, 32'h0, 1'b0, 32'd5, 32'h14);
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h20;
      step();
      check_ifid("br_over_jmp", 32'h0, 32'h0, 1'b0, 32'd5, 32'h20);
      idle_inputs();
      step();
      check_ifid("after_br", 32'h1000_0008, 32'h24, 1'b1, 32'd6, 32'h24);

      // Jump keeps the region bits of the registered PC+4
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'hF000_0010;
      step();
      check_ifid("br_hi", 32'h0, 32'h0, 1'b0, 32'd6, 32'hF000_0010);
      idle_inputs();
      step();
      check_ifid("fetch_hi", 32'h1000_0004, 32'hF000_0014, 1'b1, 32'd7, 32'hF000_0014);
      bus.Jump      = 1'b1;
      bus.JumpIndex = 26'h3;
      step();
      check_ifid("jmp_hi", 32'h0, 32'h0, 1'b0, 32'd7, 32'hF000_000C);

      // T5: 32-bit PC wrap
      idle_inputs();
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'hFFFF_FFFC;
      step();
      check_ifid("br_top", 32'h0, 32'h0, 1'b0, 32'd7, 32'hFFFF_FFFC);
      idle_inputs();
      step();
      check_ifid("wrap", 32'h1000_007F, 32'h0, 1'b1, 32'd8, 32'h0);

      // T6: run to PC=0x24, then asynchronous reset between edges
      for (int i = 0; i < 9; i++) step();
      check("pre_rst.addr",  bus.ImemAddress, 32'h24);
      check("pre_rst.count", bus.FetchCount, 32'd17);
      bus.Stall       = 1'b1;
      bus.BranchTaken = 1'b1;
      bus.BranchTarget = 32'h80;
      Reset = 1'b0;
      #2;
      check_ifid("mid_rst", 32'h0, 32'h0, 1'b0, 32'd0, 32'h0);
      #2;
      idle_inputs();
      Reset = 1'b1;
      step();
      check_ifid("restart", 32'h2010_000e, 32'd4, 1'b1, 32'd1, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
